// File: rtl/toggle_seq_pkg.sv
// Shared types and constants for the T flip-flop toggle sequencer.
package toggle_seq_pkg;

  localparam int unsigned PW_DEF        = 8;
  localparam int unsigned CW_DEF        = 8;
  localparam int unsigned SETTLE_CYCLES = 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    SETTLE,
    CHECK
  } state_e;

endpackage

// File: rtl/toggle_tick_gen.sv
// Period counter that emits a one-cycle tick every (period_m1_i + 1) enabled cycles.
module toggle_tick_gen #(
  parameter int unsigned PW = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          en_i,
  input  logic          clr_i,
  input  logic [PW-1:0] period_m1_i,
  output logic          tick_o
);

  logic [PW-1:0] cnt_q;

  assign tick_o = en_i && (cnt_q == period_m1_i);

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= tick_o ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/toggle_seq_ctrl.sv
// Burst sequencer driving the T flip-flop enable, with a parity check of the fed-back q.
module toggle_seq_ctrl
  import toggle_seq_pkg::*;
#(
  parameter int unsigned PW = PW_DEF,
  parameter int unsigned CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [PW-1:0] period,
  input  logic [CW-1:0] num_toggles,
  input  logic          q_fb,
  output logic          t,
  output logic          busy,
  output logic          done,
  output logic          mismatch,
  output logic [CW-1:0] toggles_done
);

  localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);

  state_e        state_q;
  logic [PW-1:0] period_m1_q;
  logic [CW-1:0] n_q;
  logic          q_exp_q;
  logic [SW-1:0] settle_q;
  logic          t_q;
  logic          busy_q;
  logic          done_q;
  logic          mismatch_q;
  logic [CW-1:0] td_q;

  logic tick;
  logic tick_en;
  logic tick_clr;

  assign tick_en  = (state_q == RUN) && !abort;
  assign tick_clr = (state_q == IDLE) && start;

  toggle_tick_gen #(
    .PW (PW)
  ) u_tick (
    .clk_i       (clk),
    .rst_i       (rst),
    .en_i        (tick_en),
    .clr_i       (tick_clr),
    .period_m1_i (period_m1_q),
    .tick_o      (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      period_m1_q <= '0;
      n_q         <= '0;
      q_exp_q     <= 1'b0;
      settle_q    <= '0;
      t_q         <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mismatch_q  <= 1'b0;
      td_q        <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            period_m1_q <= (period == '0) ? '0 : period - 1'b1;
            n_q         <= num_toggles;
            q_exp_q     <= q_fb;
            td_q        <= '0;
            mismatch_q  <= 1'b0;
            busy_q      <= 1'b1;
            // An empty burst still spends one settle cycle so done lands two edges after start.
            if (num_toggles == '0) begin
              settle_q <= SW'(SETTLE_CYCLES);
              state_q  <= SETTLE;
            end else begin
              settle_q <= '0;
              state_q  <= RUN;
            end
          end
        end
        RUN: begin
          if (abort) begin
            t_q     <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (tick) begin
            t_q     <= 1'b1;
            td_q    <= td_q + 1'b1;
            q_exp_q <= ~q_exp_q;
            if (td_q == n_q - 1'b1) begin
              settle_q <= '0;
              state_q  <= SETTLE;
            end
          end else begin
            t_q <= 1'b0;
          end
        end
        SETTLE: begin
          t_q <= 1'b0;
          if (abort) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (settle_q == SW'(SETTLE_CYCLES)) begin
            state_q <= CHECK;
          end else begin
            settle_q <= settle_q + 1'b1;
          end
        end
        CHECK: begin
          mismatch_q <= (q_fb != q_exp_q);
          done_q     <= 1'b1;
          busy_q     <= 1'b0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign t            = t_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign mismatch     = mismatch_q;
  assign toggles_done = td_q;

endmodule

// File: tb/tb_toggle_seq_ctrl.sv
// Randomised scoreboard bench for toggle_seq_ctrl with a behavioural T flip-flop on q_fb.
module tb_toggle_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] period = '0;
  logic [7:0] num_toggles = '0;
  logic       q_fb;
  logic       t, busy, done, mismatch;
  logic [7:0] toggles_done;

  logic tq = 1'b0;
  logic fault = 1'b0;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   idle_err = 0;
  bit   mon_en = 1'b0;

  typedef struct {
    int e0;
    int p;
    int n;
    int done_m;
    int kill_m;
    bit kill_rst;
    bit exp_mm;
  } rec_t;

  rec_t exp_q[$];

  toggle_seq_ctrl #(.PW(8), .CW(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .period       (period),
    .num_toggles  (num_toggles),
    .q_fb         (q_fb),
    .t            (t),
    .busy         (busy),
    .done         (done),
    .mismatch     (mismatch),
    .toggles_done (toggles_done)
  );

  always #5 clk = ~clk;

  // Downstream T flip-flop; the fault mode pins its observed output low.
  assign q_fb = fault ? 1'b0 : tq;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) tq <= 1'b0;
    else if (t) tq <= ~tq;
  end

  function automatic int imin(int a, int b);
    return (a < b) ? a : b;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: per-cycle expectations derived from the burst arithmetic, final check at done/kill.
  initial begin
    rec_t r;
    int m, endm, perr, first, etd;
    bit et;
    perr = 0;
    first = 0;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        r    = exp_q[0];
        m    = cyc - r.e0;
        endm = (r.kill_m > 0) ? r.kill_m : r.done_m;
        if (m < endm && !done) begin
          etd = imin(m / r.p, r.n);
          et  = (m >= r.p) && (m % r.p == 0) && (m / r.p <= r.n);
          if (t !== et || busy !== 1'b1 || mismatch !== 1'b0 || toggles_done !== 8'(etd)) begin
            if (perr == 0) first = m;
            perr++;
          end
        end else begin
          if (r.kill_m > 0) begin
            etd = r.kill_rst ? 0 : imin((r.kill_m - 1) / r.p, r.n);
            chk("kill_toggles_done", toggles_done, etd);
            chk("kill_t_busy_done_mm", {t, busy, done, mismatch}, 0);
          end else begin
            chk("done_high", done, 1);
            chk("done_latency", m, r.done_m);
            chk("mismatch", mismatch, r.exp_mm);
            chk("toggles_done", toggles_done, r.n);
            chk("t_busy_at_done", {t, busy}, 0);
          end
          if (perr != 0) $display("note: first cycle error at m=%0d", first);
          chk("cycle_pattern", perr, 0);
          perr = 0;
          void'(exp_q.pop_front());
        end
      end else if (mon_en) begin
        if (t || busy || done) idle_err++;
      end
    end
  end

  // Must be called at a negedge; returns at the negedge after the start edge E0.
  task automatic issue(int p, int n, bit flt, bit with_abort, output int e0);
    rec_t r;
    int pe;
    fault       = flt;
    period      = 8'(p);
    num_toggles = 8'(n);
    start       = 1'b1;
    abort       = with_abort;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    pe = (p == 0) ? 1 : p;
    r.e0       = cyc;
    r.p        = pe;
    r.n        = n;
    r.done_m   = (n == 0) ? 2 : n * pe + 3;
    r.kill_m   = 0;
    r.kill_rst = 1'b0;
    // q starts at 0 under fault and should end at parity of n; observed stays 0.
    r.exp_mm   = flt && (n % 2 == 1);
    exp_q.push_back(r);
    e0 = r.e0;
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() != 0) begin
      chk("wait_idle_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic wait_until(int e0, int m);
    while (cyc - e0 < m) @(negedge clk);
  endtask

  task automatic set_kill(int km, bit is_rst);
    exp_q[exp_q.size() - 1].kill_m   = km;
    exp_q[exp_q.size() - 1].kill_rst = is_rst;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, p, n, a, gap;
    bit flt;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_outputs", {t, busy, done, mismatch, toggles_done}, 0);
    mon_en = 1'b1;
    @(negedge clk);

    issue(3, 4, 1'b0, 1'b0, e0);
    wait_idle();
    issue(0, 5, 1'b0, 1'b0, e0);
    wait_idle();
    issue(5, 0, 1'b0, 1'b0, e0);
    wait_idle();

    issue(2, 3, 1'b1, 1'b0, e0);
    wait_idle();
    issue(1, 2, 1'b0, 1'b0, e0);
    wait_idle();

    issue(2, 6, 1'b0, 1'b0, e0);
    wait_until(e0, 4);
    abort = 1'b1;
    set_kill(5, 1'b0);
    @(negedge clk);
    abort = 1'b0;
    wait_idle();

    issue(2, 3, 1'b0, 1'b0, e0);
    wait_until(e0, 3);
    start = 1'b1;
    period = 8'd7;
    num_toggles = 8'd1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    issue(3, 5, 1'b0, 1'b0, e0);
    wait_until(e0, 7);
    rst = 1'b1;
    set_kill(8, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    wait_idle();

    // abort during CHECK is ignored; abort together with start in IDLE loses to start
    issue(1, 2, 1'b0, 1'b0, e0);
    wait_until(e0, 4);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_idle();
    issue(2, 2, 1'b0, 1'b1, e0);
    wait_idle();

    // start in the cycle done is high
    issue(1, 3, 1'b0, 1'b0, e0);
    wait_until(e0, 6);
    issue(2, 1, 1'b0, 1'b0, e0);
    wait_idle();

    for (int i = 0; i < 25; i++) begin
      p   = $urandom_range(0, 4);
      n   = $urandom_range(0, 6);
      flt = ($urandom_range(0, 3) == 0);
      issue(p, n, flt, 1'b0, e0);
      if (n > 0 && $urandom_range(0, 3) == 0) begin
        a = $urandom_range(0, n * ((p == 0) ? 1 : p) + 1);
        wait_until(e0, a);
        abort = 1'b1;
        set_kill(a + 1, 1'b0);
        @(negedge clk);
        abort = 1'b0;
        wait_idle();
      end else if ($urandom_range(0, 1) == 0) begin
        wait_until(e0, (n == 0) ? 2 : n * ((p == 0) ? 1 : p) + 3);
      end else begin
        wait_idle();
        gap = $urandom_range(0, 3);
        repeat (gap) @(negedge clk);
      end
    end
    wait_idle();
    fault = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_outputs_quiet", idle_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
